// File: rtl/imm_encoder_if.sv
// Handshake bundle for imm_encoder: input word channel and encoded output channel.
interface imm_encoder_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        immsrc;
    logic [31:0]       imm;
    logic [31:0]       base;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    // Producer of input words / consumer of encoded words.
    modport master (
        output in_valid, immsrc, imm, base, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    // The encoder itself.
    modport slave (
        input  in_valid, immsrc, imm, base, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: packs a signed immediate into the I/S/B/J field
// layout of a base instruction, flags out-of-range values and tags each output
// word with a running byte address.
module imm_encoder #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic         clk,
    input  logic         reset,
    imm_encoder_if.slave bus,
    output logic [15:0]  word_count,
    output logic [15:0]  err_count
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    logic [31:0]       mask;
    logic [31:0]       field;
    logic              imm_err;
    logic [31:0]       packed_word;

    logic              s1_valid;
    logic [31:0]       s1_instr;
    logic              s1_err;
    logic              s2_valid;
    logic [31:0]       s2_instr;
    logic              s2_err;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       words;
    logic [15:0]       errs;

    logic              s2_load;
    logic              s1_load;
    logic              out_fire;

    assign s2_load  = !s2_valid || bus.out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign out_fire = s2_valid && bus.out_ready;

    // Select the immediate field layout and range rule for the format code.
    always_comb begin
        mask    = '0;
        field   = '0;
        imm_err = 1'b0;
        unique case (bus.immsrc)
            2'b00: begin
                mask    = 32'hFFF0_0000;
                field   = {bus.imm[11:0], 20'b0};
                imm_err = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
            end
            2'b01: begin
                mask    = 32'hFE00_0F80;
                field   = {bus.imm[11:5], 13'b0, bus.imm[4:0], 7'b0};
                imm_err = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
            end
            2'b10: begin
                mask    = 32'hFE00_0F80;
                field   = {bus.imm[12], bus.imm[10:5], 13'b0, bus.imm[4:1], bus.imm[11], 7'b0};
                imm_err = !((&bus.imm[31:12]) || !(|bus.imm[31:12])) || bus.imm[0];
            end
            2'b11: begin
                mask    = 32'hFFFF_F000;
                field   = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], 12'b0};
                imm_err = !((&bus.imm[31:20]) || !(|bus.imm[31:20])) || bus.imm[0];
            end
        endcase
        packed_word = (bus.base & ~mask) | field;
    end

    // Pipeline stages, output address and handshake counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s1_err   <= 1'b0;
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
            addr     <= BaseAddr;
            words    <= '0;
            errs     <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
                // Keep the last word's data when a bubble moves in.
                if (s1_valid) begin
                    s2_instr <= s1_instr;
                    s2_err   <= s1_err;
                end
            end
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_instr <= packed_word;
                    s1_err   <= imm_err;
                end
            end
            if (out_fire) begin
                addr  <= addr + ADDR_W'(4);
                words <= words + 16'd1;
                if (s2_err) begin
                    errs <= errs + 16'd1;
                end
            end
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid;
    assign bus.out_instr = s2_instr;
    assign bus.out_err   = s2_err;
    assign bus.out_addr  = addr;
    assign word_count    = words;
    assign err_count     = errs;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors with hand-computed words,
// backpressure, reset flush, address wrap on a 4-bit address instance, and a
// random round-trip run checked against an independent immediate decoder.
module tb_imm_encoder;

    logic        clk;
    logic        reset;
    logic [15:0] word_count;
    logic [15:0] err_count;
    logic [15:0] word_count4;
    logic [15:0] err_count4;

    imm_encoder_if #(.ADDR_W(12)) bus ();
    imm_encoder_if #(.ADDR_W(4))  bus4 ();

    imm_encoder #(.ADDR_W(12), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .word_count (word_count),
        .err_count  (err_count)
    );

    imm_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus4),
        .word_count (word_count4),
        .err_count  (err_count4)
    );

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.immsrc    = bus.immsrc;
    assign bus4.imm       = bus.imm;
    assign bus4.base      = bus.base;
    assign bus4.out_ready = bus.out_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        rt;
        logic [1:0]  src;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [11:0] addr;
        logic [3:0]  addr4;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   idx      = 0;
    int   pop_cnt  = 0;
    int   err_pop  = 0;
    bit   rnd_en   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference immediate generator (decoder).
    function automatic logic [31:0] decode(input logic [1:0] src, input logic [31:0] x);
        case (src)
            2'b00:   return {{20{x[31]}}, x[31:20]};
            2'b01:   return {{20{x[31]}}, x[31:25], x[11:7]};
            2'b10:   return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            default: return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
        endcase
    endfunction

    // Value the field can hold after truncation to the format's width.
    function automatic logic [31:0] trunc(input logic [1:0] src, input logic [31:0] v);
        case (src)
            2'b00, 2'b01: return {{20{v[11]}}, v[11:0]};
            2'b10:        return {{19{v[12]}}, v[12:1], 1'b0};
            default:      return {{11{v[20]}}, v[20:1], 1'b0};
        endcase
    endfunction

    function automatic logic range_err(input logic [1:0] src, input logic [31:0] v);
        int s;
        s = $signed(v);
        case (src)
            2'b00, 2'b01: return !(s >= -2048 && s <= 2047);
            2'b10:        return !(s >= -4096 && s <= 4095) || v[0];
            default:      return !(s >= -1048576 && s <= 1048575) || v[0];
        endcase
    endfunction

    // Monitor: samples mid-cycle, pops on each output handshake, checks stall stability.
    initial begin
        exp_t        e;
        bit          stall_prev = 0;
        logic [31:0] st_instr   = '0;
        logic [11:0] st_addr    = '0;
        logic        st_err     = 1'b0;
        logic        e_err;
        forever begin
            @(negedge clk);
            if (!reset && stall_prev && bus.out_valid) begin
                chk("stall_instr", bus.out_instr, st_instr);
                chk("stall_addr", 32'(bus.out_addr), 32'(st_addr));
                chk("stall_err", 32'(bus.out_err), 32'(st_err));
            end
            stall_prev = !reset && bus.out_valid && !bus.out_ready;
            st_instr   = bus.out_instr;
            st_addr    = bus.out_addr;
            st_err     = bus.out_err;
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %h expected none", bus.out_instr);
                end else begin
                    e = q.pop_front();
                    if (e.rt) begin
                        e_err = range_err(e.src, e.imm);
                        chk("rt_opcode", 32'(bus.out_instr[6:0]), 32'(e.op));
                        chk("rt_field", decode(e.src, bus.out_instr), trunc(e.src, e.imm));
                        if (!e_err) chk("rt_exact", decode(e.src, bus.out_instr), e.imm);
                        chk("rt_err", 32'(bus.out_err), 32'(e_err));
                    end else begin
                        e_err = e.err;
                        chk("instr", bus.out_instr, e.instr);
                        chk("err", 32'(bus.out_err), 32'(e.err));
                    end
                    chk("addr", 32'(bus.out_addr), 32'(e.addr));
                    chk("w4_valid", 32'(bus4.out_valid), 32'd1);
                    chk("w4_addr", 32'(bus4.out_addr), 32'(e.addr4));
                    pop_cnt++;
                    if (e_err) err_pop++;
                end
            end
        end
    end

    // Random output backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic push_exp(input logic [31:0] instr, input logic err, input logic rt,
                            input logic [1:0] src, input logic [31:0] imm, input logic [6:0] op);
        exp_t e;
        e.instr = instr;
        e.err   = err;
        e.rt    = rt;
        e.src   = src;
        e.imm   = imm;
        e.op    = op;
        e.addr  = 12'((idx * 4) % 4096);
        e.addr4 = 4'((idx * 4) % 16);
        idx++;
        q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base,
                        input logic [31:0] ex_instr, input logic ex_err, input logic rt);
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.immsrc   = src;
        bus.imm      = imm;
        bus.base     = base;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                push_exp(ex_instr, ex_err, rt, src, imm, base[6:0]);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        q.delete();
        idx     = 0;
        pop_cnt = 0;
        err_pop = 0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_w4_addr", 32'(bus4.out_addr), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        int accepts;
        logic [31:0] bp_imm [4];
        logic [31:0] imm;
        logic [31:0] t;
        logic [1:0]  src;
        logic [6:0]  op;
        int          bnd [8];
        bnd = '{2047, 2048, -2048, -2049, 4094, -4096, 4096, 1048574};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.immsrc    = 2'b00;
        bus.imm       = '0;
        bus.base      = '0;

        // I-type with latency check.
        do_reset();
        bus.out_ready = 1'b1;
        send(2'b00, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0, 1'b0);
        chk("lat_s1_only", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
        drain();

        // S/B/J back to back.
        do_reset();
        bus.out_ready = 1'b1;
        send(2'b01, 32'd8,         32'h0020_A023, 32'h0020_A423, 1'b0, 1'b0);
        send(2'b10, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0, 1'b0);
        send(2'b11, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0, 1'b0);
        drain();

        // Range errors.
        do_reset();
        bus.out_ready = 1'b1;
        send(2'b00, 32'd2048, 32'h0000_0093, 32'h8000_0093, 1'b1, 1'b0);
        send(2'b10, 32'd3,    32'h0000_0063, 32'h0000_0163, 1'b1, 1'b0);
        drain();
        chk("err_count", 32'(err_count), 32'd2);
        chk("word_count", 32'(word_count), 32'd2);

        // Backpressure: only two words fit while the output is stalled.
        do_reset();
        bp_imm  = '{32'd1, 32'd2, 32'd3, 32'd4};
        accepts = 0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            bus.immsrc   = 2'b00;
            bus.imm      = bp_imm[accepts];
            bus.base     = 32'h0000_0013;
            @(negedge clk);
            if (bus.in_ready) begin
                push_exp((bp_imm[accepts] << 20) | 32'h13, 1'b0, 1'b0, 2'b00,
                         bp_imm[accepts], 7'h13);
                accepts++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("bp_accepts", 32'(accepts), 32'd2);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        send(2'b00, 32'd3, 32'h13, 32'h0030_0013, 1'b0, 1'b0);
        send(2'b00, 32'd4, 32'h13, 32'h0040_0013, 1'b0, 1'b0);
        drain();

        // Five words: the 4-bit address instance wraps back to 0.
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 5; k < 10; k++) begin
            send(2'b00, 32'(k), 32'h13, (32'(k) << 20) | 32'h13, 1'b0, 1'b0);
        end
        drain();
        chk("wrap_word_count", 32'(word_count), 32'd5);
        chk("wrap_w4_addr", 32'(bus4.out_addr), 32'd4);

        // Reset with both stages full: nothing stale may come out.
        do_reset();
        bus.out_ready = 1'b0;
        send(2'b00, 32'd11, 32'h13, 32'h00B0_0013, 1'b0, 1'b0);
        send(2'b00, 32'd12, 32'h13, 32'h00C0_0013, 1'b0, 1'b0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
        end
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_word_count", 32'(word_count), 32'd0);

        // Random round trip with random backpressure.
        do_reset();
        rnd_en = 1;
        for (int n = 0; n < 10000; n++) begin
            src = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
                2: begin
                    t   = $urandom;
                    imm = {{11{t[20]}}, t[20:0]};
                end
                default: imm = 32'(bnd[$urandom_range(0, 7)]);
            endcase
            if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
            op = 7'($urandom);
            send(src, imm, {25'b0, op}, 32'd0, 1'b0, 1'b1);
        end
        rnd_en = 0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        drain();
        chk("rnd_word_count", 32'(word_count), 32'(pop_cnt[15:0]));
        chk("rnd_err_count", 32'(err_count), 32'(err_pop[15:0]));
        chk("rnd_word_total", 32'(pop_cnt), 32'd10000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
